mux_scan_ctrl: RTL and testbench

Upstream driver for the 8:1 `multiplexer`. It accepts a byte over a valid/ready handshake and holds it on the multiplexer `data` input. It then steps `address` through 0..7, dwelling a programmable number of cycles on each select, and samples the multiplexer's `out` at the end of each dwell. The result is the byte as a framed serial bit stream (bit 0 first), with a last-bit marker for the downstream consumer.

---
 rtl/mux_scan_pkg.sv | 19 +
 rtl/scan_tick_gen.sv | 40 ++++
 rtl/mux_scan_ctrl.sv | 119 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexer scan controller.
// No logic; state encoding, default sizing and select-width derivation.
// Not applicable (no datapath or flow control in a package).
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int DWELL_DEF  = 10;
    localparam int CNT_W      = 8;

    function automatic int addr_w(input int data_w);
        return (data_w <= 1) ? 1 : $clog2(data_w);
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Dwell counter: one-cycle tick on the cycle the count reaches DWELL-1.
// Latency: tick is combinational from the count register; wraps to 0 on tick.
// Backpressure: none; clr overrides counting and tick-wrap.
module scan_tick_gen
    import mux_scan_pkg::*;
#(
    parameter int DWELL = DWELL_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Holds an accepted byte on the mux data bus and walks the select 0..DATA_W-1, emitting one sampled bit per dwell.
// Latency: first bit strobe DWELL cycles after accept, one per DWELL after that; DATA_W*DWELL per byte.
// Backpressure: in_ready low for the whole scan; in_valid is ignored until the scan ends or is flushed.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = addr_w(DATA_W),
    parameter int DWELL  = DWELL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] mux_address,
    output logic [DATA_W-1:0] mux_data,
    input  logic              mux_out,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              bit_last,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DATA_W - 1);

    state_t state_q;
    state_t state_d;

    logic accept;
    logic flush_scan;
    logic tick;
    logic sample;
    logic last_addr;

    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic              bit_out_d;
    logic              bit_valid_d;
    logic              bit_last_d;
    logic              busy_d;
    logic              in_ready_d;

    assign accept     = (state_q == IDLE) && in_valid && in_ready;
    assign flush_scan = (state_q == SCAN) && flush;
    // flush wins over a sample that lands on the same edge
    assign sample     = tick && !flush_scan;
    assign last_addr  = (mux_address == ADDR_LAST);

    scan_tick_gen #(
        .DWELL (DWELL)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept || flush_scan),
        .en    (state_q == SCAN),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SCAN;
            SCAN: if (flush_scan || (sample && last_addr)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d      = mux_address;
        data_d      = mux_data;
        bit_out_d   = bit_out;
        bit_valid_d = 1'b0;
        bit_last_d  = 1'b0;
        busy_d      = (state_d == SCAN);
        in_ready_d  = (state_d == IDLE);
        if (accept) begin
            data_d = in_data;
            addr_d = '0;
        end else if (flush_scan) begin
            addr_d = '0;
        end else if (sample) begin
            bit_out_d   = mux_out;
            bit_valid_d = 1'b1;
            bit_last_d  = last_addr;
            addr_d      = mux_address + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_address <= '0;
            mux_data    <= '0;
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            bit_last    <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            mux_address <= addr_d;
            mux_data    <= data_d;
            bit_out     <= bit_out_d;
            bit_valid   <= bit_valid_d;
            bit_last    <= bit_last_d;
            busy        <= busy_d;
            in_ready    <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one DUT at DWELL=10, one at DWELL=1, each closed through a behavioural 8:1 mux.
module tb_mux_scan_ctrl;

    localparam int DWELL_A = 10;
    localparam int DWELL_B = 1;

    typedef struct {
        logic [7:0] data;
        logic [0:7] seq;
    } vec_t;

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] a_in_data, b_in_data;
    logic       a_in_valid, b_in_valid, a_in_ready, b_in_ready;
    logic       a_flush, b_flush;
    logic [2:0] a_mux_address, b_mux_address;
    logic [7:0] a_mux_data, b_mux_data;
    logic       a_mux_out, b_mux_out;
    logic       a_bit_out, b_bit_out, a_bit_valid, b_bit_valid;
    logic       a_bit_last, b_bit_last, a_busy, b_busy;

    assign a_mux_out = a_mux_data[a_mux_address];
    assign b_mux_out = b_mux_data[b_mux_address];

    mux_scan_ctrl #(.DATA_W(8), .DWELL(DWELL_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .flush(a_flush), .mux_address(a_mux_address),
        .mux_data(a_mux_data), .mux_out(a_mux_out), .bit_out(a_bit_out),
        .bit_valid(a_bit_valid), .bit_last(a_bit_last), .busy(a_busy)
    );

    mux_scan_ctrl #(.DATA_W(8), .DWELL(DWELL_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .flush(b_flush), .mux_address(b_mux_address),
        .mux_data(b_mux_data), .mux_out(b_mux_out), .bit_out(b_bit_out),
        .bit_valid(b_bit_valid), .bit_last(b_bit_last), .busy(b_busy)
    );

    vec_t a_pend[$];
    vec_t b_pend[$];
    exp_t qa[$];
    exp_t qb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int a_ref = 0;
    int b_ref = 0;
    int b_acc_cnt = 0;
    int b_nstrobe = 0;
    int b_last_cyc = 0;
    logic b_acc_flag = 1'b0;
    logic a_acc_chk = 1'b0;
    logic [7:0] a_exp_data = 8'h00;
    logic [7:0] b_prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept detection: expected bit stream enters the scoreboard on the accept edge.
    always @(posedge clk) begin : acc_p
        vec_t v;
        exp_t e;
        cyc = cyc + 1;
        if (a_in_valid && a_in_ready) begin
            check("a_accept_pending", a_pend.size() != 0, 1);
            if (a_pend.size() != 0) begin
                v = a_pend.pop_front();
                for (int j = 0; j < 8; j++) begin
                    e.b = v.seq[j];
                    e.last = (j == 7);
                    qa.push_back(e);
                end
                a_exp_data = v.data;
                a_acc_chk  = 1'b1;
            end
            a_ref = cyc;
        end
        if (b_in_valid && b_in_ready) begin
            check("b_accept_pending", b_pend.size() != 0, 1);
            if (b_pend.size() != 0) begin
                v = b_pend.pop_front();
                for (int j = 0; j < 8; j++) begin
                    e.b = v.seq[j];
                    e.last = (j == 7);
                    qb.push_back(e);
                end
            end
            b_ref = cyc;
            b_acc_cnt++;
            b_acc_flag = 1'b1;
        end
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_acc_chk) begin
            check("a_mux_data_latch", a_mux_data, a_exp_data);
            check("a_addr_at_accept", a_mux_address, 0);
            a_acc_chk = 1'b0;
        end
        if (a_bit_valid) begin
            if (qa.size() == 0) begin
                check("a_unexpected_strobe", a_bit_valid, 0);
            end else begin
                e = qa.pop_front();
                check("a_bit", a_bit_out, e.b);
                check("a_last", a_bit_last, e.last);
                check("a_spacing", cyc - a_ref, DWELL_A);
                a_ref = cyc;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_mux_data !== b_prev_data) begin
            check("b_mux_data_change_at_accept", b_acc_flag, 1);
        end
        b_prev_data = b_mux_data;
        b_acc_flag  = 1'b0;
        if (b_bit_valid) begin
            if (qb.size() == 0) begin
                check("b_unexpected_strobe", b_bit_valid, 0);
            end else begin
                e = qb.pop_front();
                check("b_bit", b_bit_out, e.b);
                check("b_last", b_bit_last, e.last);
                if (b_nstrobe == 0) check("b_first_latency", cyc - b_ref, DWELL_B);
                else if (b_nstrobe == 8) check("b_idle_gap", cyc - b_last_cyc, 2);
                else check("b_continuous", cyc - b_last_cyc, 1);
            end
            b_nstrobe++;
            b_last_cyc = cyc;
        end
    end

    task automatic send_a(input vec_t v);
        for (int k = 0; k < 200 && !a_in_ready; k++) @(negedge clk);
        check("a_ready_before_send", a_in_ready, 1);
        @(negedge clk);
        a_pend.push_back(v);
        a_in_data  = v.data;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
    endtask

    task automatic wait_a_done(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!a_busy && qa.size() == 0) break;
        end
        check("a_done_in_budget", (k < budget) ? 1 : 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    vec_t tbl[5];
    vec_t v3c, vff, vc8, v00, v01;

    initial begin
        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_flush = 1'b0;
        b_in_data = '0; b_in_valid = 1'b0; b_flush = 1'b0;
        tbl[0] = '{8'hA5, 8'b1010_0101};
        tbl[1] = '{8'h01, 8'b1000_0000};
        tbl[2] = '{8'hC8, 8'b0001_0011};
        tbl[3] = '{8'h5A, 8'b0101_1010};
        tbl[4] = '{8'hFF, 8'b1111_1111};
        v3c = '{8'h3C, 8'b0011_1100};
        vff = '{8'hFF, 8'b1111_1111};
        vc8 = '{8'hC8, 8'b0001_0011};
        v00 = '{8'h00, 8'b0000_0000};
        v01 = '{8'h01, 8'b1000_0000};

        // Reset values and in_ready release timing
        repeat (3) @(negedge clk);
        check("a_reset_outputs", {a_mux_address, a_mux_data, a_bit_out, a_bit_valid, a_bit_last, a_busy, a_in_ready}, 0);
        check("b_reset_outputs", {b_mux_address, b_mux_data, b_bit_out, b_bit_valid, b_bit_last, b_busy, b_in_ready}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("a_in_ready_before_first_edge", a_in_ready, 0);
        @(negedge clk);
        check("a_in_ready_after_release", a_in_ready, 1);
        check("a_addr_after_release", a_mux_address, 0);
        check("a_busy_after_release", a_busy, 0);

        // Single bytes from the table
        for (int i = 0; i < 5; i++) begin
            send_a(tbl[i]);
            @(negedge clk);
            check("a_busy_during_scan", a_busy, 1);
            check("a_in_ready_during_scan", a_in_ready, 0);
            wait_a_done(200);
            check("a_busy_end", a_busy, 0);
            check("a_addr_end", a_mux_address, 0);
            check("a_in_ready_end", a_in_ready, 1);
            check("a_mux_data_held", a_mux_data, tbl[i].data);
        end

        // Flush on the sampling edge of address 3
        send_a(v3c);
        repeat (DWELL_A * 4 - 1) @(posedge clk);
        check("a_addr_before_flush", a_mux_address, 3);
        #1 a_flush = 1'b1;
        @(posedge clk);
        #1 a_flush = 1'b0;
        check("a_bits_left_at_flush", qa.size(), 5);
        qa.delete();
        @(negedge clk);
        check("a_no_strobe_at_flush", a_bit_valid, 0);
        check("a_last_at_flush", a_bit_last, 0);
        check("a_in_ready_after_flush", a_in_ready, 1);
        check("a_busy_after_flush", a_busy, 0);
        check("a_addr_after_flush", a_mux_address, 0);
        repeat (30) @(negedge clk);

        // in_valid while busy is ignored
        send_a(vff);
        repeat (35) @(posedge clk);
        #1 a_in_data = v00.data;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        wait_a_done(200);
        repeat (20) @(negedge clk);
        check("a_idle_after_ignored", a_busy, 0);
        check("a_mux_data_after_ignored", a_mux_data, 8'hFF);

        // Async reset between edges while on address 5
        send_a(vc8);
        repeat (DWELL_A * 5 + 5) @(posedge clk);
        check("a_addr_before_reset", a_mux_address, 5);
        #3 rst_n = 1'b0;
        #1;
        check("a_async_reset_outputs", {a_mux_address, a_mux_data, a_bit_out, a_bit_valid, a_bit_last, a_busy, a_in_ready}, 0);
        qa.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        send_a(tbl[3]);
        wait_a_done(200);
        check("a_busy_after_reset_rescan", a_busy, 0);

        // Back-to-back bytes with DWELL=1
        @(negedge clk);
        b_pend.push_back(vff);
        b_pend.push_back(v01);
        b_in_data  = vff.data;
        b_in_valid = 1'b1;
        for (int k = 0; k < 50 && b_acc_cnt < 1; k++) begin
            @(posedge clk);
            #1;
        end
        b_in_data = v01.data;
        for (int k = 0; k < 50 && b_acc_cnt < 2; k++) begin
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        check("b_accept_count", b_acc_cnt, 2);
        for (int k = 0; k < 50 && (b_busy || qb.size() != 0); k++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("b_strobe_count", b_nstrobe, 16);
        check("b_busy_end", b_busy, 0);
        check("b_queue_drained", qb.size(), 0);
        check("a_queue_drained", qa.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
